usb_rst_sequencer: RTL and testbench

USB_RST_SEQUENCER -- requirements
Module: usb_rst_sequencer

---
 rtl/usb_rst_sequencer.sv | 145 ++++++++++++++
 tb/tb_usb_rst_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/usb_rst_sequencer.sv
// Avalon-MM programmable reset sequencer for an external USB controller:
// holds the chip in reset, then drives a timed assert pulse and settle wait.
module usb_rst_sequencer #(
    parameter logic [15:0] DEF_ASSERT_CYC = 16'd50000,
    parameter logic [15:0] DEF_WAIT_CYC   = 16'd50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        usb_rst_n,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_IDLE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] assert_cyc_q, assert_cyc_d;
    logic [15:0] wait_cyc_q, wait_cyc_d;
    logic [15:0] sh_assert_q, sh_assert_d;
    logic [15:0] sh_wait_q, sh_wait_d;
    logic        done_q, done_d;
    logic        irq_en_q, irq_en_d;
    logic        usb_rst_n_q, usb_rst_n_d;
    logic        irq_q, irq_d;

    logic wr, start_wr, hold_wr, done_clr, done_set;
    logic busy, held;
    logic unused_wd;

    assign unused_wd = ^writedata[31:16];

    assign wr       = chipselect & ~write_n;
    assign start_wr = wr && (address == 2'd0) && writedata[0];
    assign hold_wr  = wr && (address == 2'd0) && writedata[2];
    assign done_clr = wr && (address == 2'd1) && writedata[1];

    assign busy = (state_q == ST_ASSERT) || (state_q == ST_WAIT);
    assign held = (state_q == ST_HOLD);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        assert_cyc_d = assert_cyc_q;
        wait_cyc_d   = wait_cyc_q;
        sh_assert_d  = sh_assert_q;
        sh_wait_d    = sh_wait_q;
        irq_en_d     = irq_en_q;
        done_set     = 1'b0;

        if (wr && (address == 2'd0)) irq_en_d = writedata[1];
        if (wr && (address == 2'd2)) assert_cyc_d = writedata[15:0];
        if (wr && (address == 2'd3)) wait_cyc_d = writedata[15:0];

        // HOLD beats START and any in-flight sequence
        if (hold_wr) begin
            state_d = ST_HOLD;
            cnt_d   = 16'd0;
        end else begin
            case (state_q)
                ST_HOLD, ST_IDLE: begin
                    if (start_wr) begin
                        state_d     = ST_ASSERT;
                        sh_assert_d = assert_cyc_q;
                        sh_wait_d   = wait_cyc_q;
                        cnt_d       = (assert_cyc_q == 16'd0) ? 16'd1 : assert_cyc_q;
                    end
                end
                ST_ASSERT: begin
                    if (cnt_q <= 16'd1) begin
                        state_d = ST_WAIT;
                        cnt_d   = (sh_wait_q == 16'd0) ? 16'd1 : sh_wait_q;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q <= 16'd1) begin
                        state_d  = ST_IDLE;
                        cnt_d    = 16'd0;
                        done_set = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                default: state_d = ST_HOLD;
            endcase
        end

        // set has priority over a simultaneous software clear
        done_d      = done_set ? 1'b1 : (done_clr ? 1'b0 : done_q);
        usb_rst_n_d = (state_d == ST_WAIT) || (state_d == ST_IDLE);
        irq_d       = done_d & irq_en_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_HOLD;
            cnt_q        <= 16'd0;
            assert_cyc_q <= DEF_ASSERT_CYC;
            wait_cyc_q   <= DEF_WAIT_CYC;
            sh_assert_q  <= DEF_ASSERT_CYC;
            sh_wait_q    <= DEF_WAIT_CYC;
            done_q       <= 1'b0;
            irq_en_q     <= 1'b0;
            usb_rst_n_q  <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            assert_cyc_q <= assert_cyc_d;
            wait_cyc_q   <= wait_cyc_d;
            sh_assert_q  <= sh_assert_d;
            sh_wait_q    <= sh_wait_d;
            done_q       <= done_d;
            irq_en_q     <= irq_en_d;
            usb_rst_n_q  <= usb_rst_n_d;
            irq_q        <= irq_d;
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0: readdata = {30'd0, irq_en_q, 1'b0};
            2'd1: readdata = {29'd0, held, done_q, busy};
            2'd2: readdata = {16'd0, assert_cyc_q};
            2'd3: readdata = {16'd0, wait_cyc_q};
            default: readdata = 32'd0;
        endcase
    end

    assign usb_rst_n = usb_rst_n_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_usb_rst_sequencer.sv
// Directed bench for usb_rst_sequencer: register access, pulse timing,
// busy writes, HOLD abort, interrupt and asynchronous reset behaviour.
module tb_usb_rst_sequencer;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        usb_rst_n;
    logic        irq;

    int checks;
    int failures;
    logic [0:0] exp_q[$];

    usb_rst_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .usb_rst_n  (usb_rst_n),
        .irq        (irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; consumes exactly one rising edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    // Call right after the START write; checks the whole pulse cycle by cycle.
    task automatic run_seq(input int n_low, input int n_wait, input string tag);
        logic [31:0] st;
        logic [0:0]  e;
        for (int i = 0; i < n_low; i++)  exp_q.push_back(1'b0);
        for (int i = 0; i < n_wait; i++) exp_q.push_back(1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            bus_read(2'd1, st);
            check({tag, "_rst_n"}, {31'd0, usb_rst_n}, {31'd0, e});
            check({tag, "_busy"}, {31'd0, st[0]}, 32'd1);
            @(negedge clk);
        end
        bus_read(2'd1, st);
        check({tag, "_end_status"}, st, 32'h2);
        check({tag, "_end_rst_n"}, {31'd0, usb_rst_n}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int n;
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_usb_rst_n", {31'd0, usb_rst_n}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus_read(2'd1, rd); check("rst_status", rd, 32'h4);
        bus_read(2'd2, rd); check("rst_assert_cyc", rd, 32'd50000);
        bus_read(2'd3, rd); check("rst_wait_cyc", rd, 32'd50000);
        bus_read(2'd0, rd); check("rst_ctrl", rd, 32'h0);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (usb_rst_n !== 1'b0) n++;
        end
        check("hold_1000_high_cycles", n, 0);

        // normal sequence 5 + 3
        bus_write(2'd2, 32'd5);
        bus_write(2'd3, 32'd3);
        bus_read(2'd2, rd); check("assert_cyc_rb", rd, 32'd5);
        bus_read(2'd3, rd); check("wait_cyc_rb", rd, 32'd3);
        @(negedge clk);
        bus_write(2'd0, 32'h1);
        run_seq(5, 3, "norm");
        check("norm_irq", {31'd0, irq}, 32'd0);
        bus_read(2'd0, rd); check("norm_ctrl", rd, 32'h0);

        // zero counts, upper write bits ignored, interrupt
        @(negedge clk);
        bus_write(2'd1, 32'h2);
        bus_read(2'd1, rd); check("done_clr_status", rd, 32'h0);
        @(negedge clk);
        bus_write(2'd2, 32'hDEAD_0000);
        bus_write(2'd3, 32'hFFFF_0000);
        bus_read(2'd2, rd); check("assert_cyc_hi_ignored", rd, 32'h0);
        @(negedge clk);
        bus_write(2'd0, 32'h3);
        run_seq(1, 1, "zero");
        check("zero_irq", {31'd0, irq}, 32'd1);
        bus_read(2'd0, rd); check("zero_ctrl", rd, 32'h2);
        @(negedge clk);
        bus_write(2'd1, 32'h2);
        check("irq_clr", {31'd0, irq}, 32'd0);

        // writes while busy
        bus_write(2'd2, 32'd10);
        bus_write(2'd3, 32'd1);
        bus_write(2'd0, 32'h1);
        check("busy_low_i0", {31'd0, usb_rst_n}, 32'd0);
        bus_write(2'd2, 32'd2);
        bus_write(2'd0, 32'h1);
        bus_read(2'd2, rd); check("busy_assert_cyc_rb", rd, 32'd2);
        @(negedge clk);
        n = 3;
        while (usb_rst_n === 1'b0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("busy_pulse_len", n, 10);
        @(negedge clk);
        bus_read(2'd1, rd); check("busy_end_status", rd, 32'h2);
        @(negedge clk);
        bus_write(2'd0, 32'h1);
        run_seq(2, 1, "short");

        // HOLD abort during WAIT
        @(negedge clk);
        bus_write(2'd1, 32'h2);
        bus_write(2'd2, 32'd2);
        bus_write(2'd3, 32'd20);
        bus_write(2'd0, 32'h1);
        repeat (3) @(negedge clk);
        check("abort_in_wait", {31'd0, usb_rst_n}, 32'd1);
        bus_write(2'd0, 32'h5);
        check("abort_rst_n", {31'd0, usb_rst_n}, 32'd0);
        bus_read(2'd1, rd); check("abort_status", rd, 32'h4);
        repeat (5) @(negedge clk);
        bus_read(2'd1, rd); check("abort_stays_hold", rd, 32'h4);

        // DONE set beats a same-cycle clear
        @(negedge clk);
        bus_write(2'd2, 32'd1);
        bus_write(2'd3, 32'd1);
        bus_write(2'd0, 32'h3);
        @(negedge clk);
        bus_write(2'd1, 32'h2);
        bus_read(2'd1, rd); check("set_beats_clr", rd, 32'h2);
        check("set_beats_clr_irq", {31'd0, irq}, 32'd1);

        // async reset during ASSERT
        @(negedge clk);
        bus_write(2'd2, 32'd100);
        bus_write(2'd0, 32'h3);
        check("pre_areset_rst_n", {31'd0, usb_rst_n}, 32'd0);
        check("pre_areset_irq", {31'd0, irq}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_irq", {31'd0, irq}, 32'd0);
        check("areset_rst_n", {31'd0, usb_rst_n}, 32'd0);
        bus_read(2'd1, rd); check("areset_status", rd, 32'h4);
        @(negedge clk);
        bus_read(2'd2, rd); check("areset_assert_cyc", rd, 32'd50000);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        bus_read(2'd1, rd); check("post_areset_status", rd, 32'h4);
        bus_read(2'd0, rd); check("post_areset_ctrl", rd, 32'h0);
        check("post_areset_rst_n", {31'd0, usb_rst_n}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
